// File: rtl/asynch_receiver_if.sv
// Line/word interface for the asynchronous serial receiver.
// The master drives the serial line; the slave (receiver) returns the recovered word and status.
`timescale 1ns/1ps
interface asynch_receiver_if #(
    parameter int unsigned D = 8
) ();
    logic         rxd;
    logic [D-1:0] data;
    logic         valid;
    logic         ferr;
    logic         busy;

    modport master (
        output rxd,
        input  data,
        input  valid,
        input  ferr,
        input  busy
    );

    modport slave (
        input  rxd,
        output data,
        output valid,
        output ferr,
        output busy
    );
endinterface

// File: rtl/asynch_receiver.sv
// UART-style frame receiver: start bit, D data bits LSB first, one stop bit.
// Self-timed from clk with BIT_CLKS cycles per bit; emits one-cycle valid/ferr pulses.
`timescale 1ns/1ps
module asynch_receiver #(
    parameter int unsigned D        = 8,
    parameter int unsigned BIT_CLKS = 16,
    parameter int unsigned CW       = $clog2(BIT_CLKS)
) (
    input  logic           clk,
    input  logic           reset,
    asynch_receiver_if.slave rx
);
    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         r_state;
    logic [1:0]     r_sync;
    logic           r_rs_d;
    logic [CW-1:0]  r_cnt;
    logic [IW-1:0]  r_idx;
    logic [D-1:0]   r_shift;
    logic [D-1:0]   r_data;
    logic           r_valid;
    logic           r_ferr;
    logic           r_busy;

    logic           w_rs;
    logic [D-1:0]   w_shift_next;

    assign w_rs = r_sync[1];
    // New bit enters at the MSB so the first bit on the line ends up in bit 0.
    assign w_shift_next = D'({w_rs, r_shift} >> 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sync  <= 2'b11;
            r_rs_d  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx.rxd};
            r_rs_d  <= w_rs;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;

            case (r_state)
                // Arm only on a true 1->0 transition so a held-low line never re-triggers.
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rs && r_rs_d) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                // Confirm the start bit at its centre; a high line there means a glitch.
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (!w_rs) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                // Leave mid-stop-bit so a start bit immediately following is still seen.
                S_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (w_rs) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx.data  = r_data;
    assign rx.valid = r_valid;
    assign rx.ferr  = r_ferr;
    assign rx.busy  = r_busy;

endmodule
